// File: rtl/color_matrix_pkg.sv
// Shared constants for the colour-matrix converter: pipeline latency,
// configuration address map and BT.601 full-range reset defaults.
package color_matrix_pkg;

  localparam int unsigned LAT = 4;

  localparam logic [3:0] CFG_COEF_LAST = 4'd8;
  localparam logic [3:0] CFG_OFF_FIRST = 4'd9;
  localparam logic [3:0] CFG_OFF_LAST  = 4'd11;

  // Coefficients at FRAC_W = 16, rows Y, Cb, Cr; offsets at DATA_W = 8
  localparam int DEF_COEF [9] = '{ 19595,  38470,   7471,
                                  -11059, -21709,  32768,
                                   32768, -27439,  -5329};
  localparam int DEF_OFF [3] = '{0, 128, 128};

  function automatic longint scale_pow2(input longint v, input int sh);
    if (sh >= 0) return v <<< sh;
    else         return v >>> (-sh);
  endfunction

endpackage

// File: rtl/delayline.sv
// Fixed-length shift register for side-band signals, synchronously cleared.
module delayline #(
  parameter int unsigned N     = 1,
  parameter int unsigned DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] taps [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DELAY; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DELAY; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DELAY-1];

endmodule

// File: rtl/color_matrix_conv.sv
// 3x3 colour matrix with offsets and clamping, 4-stage pipeline, bypass mode
// and a shadow/active coefficient bank swapped on the vsync rising edge.
module color_matrix_conv
  import color_matrix_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  de_in,
  input  logic [3*DATA_W-1:0]   pixel_in,
  input  logic                  mode,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [COEF_W-1:0]     cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_pending,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  de_out,
  output logic [3*DATA_W-1:0]   pixel_out
);

  localparam int PIX_W  = 3*DATA_W;
  localparam int OFF_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 2;
  localparam int RES_W  = SUM_W + 1;

  localparam logic signed [SUM_W-1:0] ROUND_C =
    {{(SUM_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [RES_W-1:0] CH_MAX =
    {{(RES_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  function automatic logic signed [COEF_W-1:0] def_coef(input int unsigned i);
    return COEF_W'(scale_pow2(longint'(DEF_COEF[i]), FRAC_W - 16));
  endfunction

  function automatic logic signed [OFF_W-1:0] def_off(input int unsigned i);
    return OFF_W'(scale_pow2(longint'(DEF_OFF[i]), DATA_W - 8));
  endfunction

  function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_W-1:0] c,
                                                    input logic signed [COEF_W-1:0] k);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'({1'b0, c});
    b = PROD_W'(k);
    return a * b;
  endfunction

  // ---------------- configuration banks ----------------
  logic signed [COEF_W-1:0] shadow_coef [9];
  logic signed [COEF_W-1:0] active_coef [9];
  logic signed [OFF_W-1:0]  shadow_off  [3];
  logic signed [OFF_W-1:0]  active_off  [3];
  logic signed [COEF_W-1:0] coef_next   [9];
  logic signed [OFF_W-1:0]  off_next    [3];
  logic                     vsync_prev;
  logic                     transfer;
  logic [1:0]               off_idx;

  assign transfer = vsync_in & ~vsync_prev & (cfg_pending | cfg_commit);

  // S1 samples the bank as it will be after this edge, so the pixel taken on
  // the transfer edge already sees the new coefficients.
  always_comb begin
    off_idx = 2'(cfg_addr - CFG_OFF_FIRST);
    for (int unsigned i = 0; i < 9; i++)
      coef_next[i] = transfer ? shadow_coef[i] : active_coef[i];
    for (int unsigned i = 0; i < 3; i++)
      off_next[i] = transfer ? shadow_off[i] : active_off[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) begin
        shadow_coef[i] <= def_coef(i);
        active_coef[i] <= def_coef(i);
      end
      for (int unsigned i = 0; i < 3; i++) begin
        shadow_off[i] <= def_off(i);
        active_off[i] <= def_off(i);
      end
      cfg_pending <= 1'b0;
      vsync_prev  <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (transfer) begin
        active_coef <= shadow_coef;
        active_off  <= shadow_off;
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
      if (cfg_we) begin
        if (cfg_addr <= CFG_COEF_LAST)
          shadow_coef[cfg_addr] <= cfg_data;
        else if (cfg_addr <= CFG_OFF_LAST)
          shadow_off[off_idx] <= cfg_data[OFF_W-1:0];
      end
    end
  end

  // ---------------- datapath ----------------
  logic [PIX_W-1:0]         pix_s1, pix_s2, pix_s3;
  logic                     mode_s1, mode_s2, mode_s3;
  logic signed [COEF_W-1:0] coef_s1 [9];
  logic signed [OFF_W-1:0]  off_s1 [3];
  logic signed [OFF_W-1:0]  off_s2 [3];
  logic signed [OFF_W-1:0]  off_s3 [3];
  logic signed [PROD_W-1:0] prod_s2 [9];
  logic signed [SUM_W-1:0]  sum_s3 [3];
  logic [PIX_W-1:0]         conv_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_s1    <= '0;
      pix_s2    <= '0;
      pix_s3    <= '0;
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      mode_s3   <= 1'b0;
      pixel_out <= '0;
      for (int unsigned i = 0; i < 9; i++) begin
        coef_s1[i] <= '0;
        prod_s2[i] <= '0;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        off_s1[i] <= '0;
        off_s2[i] <= '0;
        off_s3[i] <= '0;
        sum_s3[i] <= '0;
      end
    end else begin
      pix_s1  <= pixel_in;
      mode_s1 <= mode;
      coef_s1 <= coef_next;
      off_s1  <= off_next;

      pix_s2  <= pix_s1;
      mode_s2 <= mode_s1;
      off_s2  <= off_s1;
      for (int unsigned i = 0; i < 9; i++)
        prod_s2[i] <= mul(pix_s1[(2 - i % 3)*DATA_W +: DATA_W], coef_s1[i]);

      pix_s3  <= pix_s2;
      mode_s3 <= mode_s2;
      off_s3  <= off_s2;
      for (int unsigned r = 0; r < 3; r++)
        sum_s3[r] <= SUM_W'(prod_s2[3*r]) + SUM_W'(prod_s2[3*r+1]) + SUM_W'(prod_s2[3*r+2]);

      pixel_out <= mode_s3 ? conv_pix : pix_s3;
    end
  end

  always_comb begin
    logic signed [SUM_W-1:0] rnd;
    logic signed [RES_W-1:0] res;
    conv_pix = '0;
    rnd      = '0;
    res      = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      rnd = (sum_s3[r] + ROUND_C) >>> FRAC_W;
      res = RES_W'(rnd) + RES_W'(off_s3[r]);
      if (res[RES_W-1])
        conv_pix[(2-r)*DATA_W +: DATA_W] = '0;
      else if (res > CH_MAX)
        conv_pix[(2-r)*DATA_W +: DATA_W] = '1;
      else
        conv_pix[(2-r)*DATA_W +: DATA_W] = res[DATA_W-1:0];
    end
  end

  // ---------------- timing alignment ----------------
  logic [2:0] timing_q;

  delayline #(.N(3), .DELAY(LAT)) u_timing (
    .clk  (clk),
    .rst  (rst),
    .din  ({hsync_in, vsync_in, de_in}),
    .dout (timing_q)
  );

  assign hsync_out = timing_q[2];
  assign vsync_out = timing_q[1];
  assign de_out    = timing_q[0];

endmodule
